// File: rtl/retire_trace_buffer.sv
// Retirement trace queue beside writeback: records every retiring instruction
// for an off-core consumer and counts retirements and drops.
module retire_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     wb_valid,
    input  logic [31:0]              wb_instr,
    input  logic [4:0]               wb_rd,
    input  logic                     wb_regwrite,
    input  logic [31:0]              wb_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_instr,
    output logic [4:0]               trace_rd,
    output logic                     trace_we,
    output logic [31:0]              trace_data,
    output logic [SEQ_W-1:0]         trace_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              retired_count,
    output logic [15:0]              dropped_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic             we;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    rec_t          wr_rec;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign trace_valid = (level != '0);
    assign full        = (level == LW'(DEPTH));
    assign pop         = trace_valid & trace_ready & ~clr;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push        = wb_valid & ~clr & (~full | (trace_valid & trace_ready));
    assign drop        = wb_valid & ~clr & ~push;

    always_comb begin
        wr_rec       = '0;
        wr_rec.instr = wb_instr;
        wr_rec.rd    = wb_rd;
        wr_rec.we    = wb_regwrite & (wb_rd != 5'd0);
        wr_rec.data  = wb_data;
        wr_rec.seq   = retired_count[SEQ_W-1:0];
    end

    // Storage is deliberately not reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    assign head        = mem[rd_ptr];
    assign trace_instr = trace_valid ? head.instr : '0;
    assign trace_rd    = trace_valid ? head.rd    : '0;
    assign trace_we    = trace_valid ? head.we    : 1'b0;
    assign trace_data  = trace_valid ? head.data  : '0;
    assign trace_seq   = trace_valid ? head.seq   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            retired_count <= '0;
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else if (clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            retired_count <= '0;
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (wb_valid) begin
                retired_count <= retired_count + 32'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (dropped_count != 16'hFFFF) begin
                    dropped_count <= dropped_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: directed scenarios followed by
// randomized traffic against a queue-level reference model.
module tb_retire_trace_buffer;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              clr;
    logic              wb_valid;
    logic [31:0]       wb_instr;
    logic [4:0]        wb_rd;
    logic              wb_regwrite;
    logic [31:0]       wb_data;
    logic              trace_valid;
    logic              trace_ready;
    logic [31:0]       trace_instr;
    logic [4:0]        trace_rd;
    logic              trace_we;
    logic [31:0]       trace_data;
    logic [SEQ_W-1:0]  trace_seq;
    logic [3:0]        level;
    logic [31:0]       retired_count;
    logic [15:0]       dropped_count;
    logic              overflow;

    retire_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .clr           (clr),
        .wb_valid      (wb_valid),
        .wb_instr      (wb_instr),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .wb_data       (wb_data),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_instr   (trace_instr),
        .trace_rd      (trace_rd),
        .trace_we      (trace_we),
        .trace_data    (trace_data),
        .trace_seq     (trace_seq),
        .level         (level),
        .retired_count (retired_count),
        .dropped_count (dropped_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic             we;
        logic [31:0]      data;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    rec_t        sb [$];
    int          mlevel = 0;
    logic [31:0] mret   = '0;
    int          mdrop  = 0;
    bit          movf   = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the model between clock edges.
    always @(negedge clk) begin
        rec_t got;
        got = '{trace_instr, trace_rd, trace_we, trace_data, trace_seq};
        chk("level", level, mlevel);
        chk("valid", trace_valid, mlevel != 0);
        chk("retired", retired_count, mret);
        chk("dropped", dropped_count, mdrop);
        chk("overflow", overflow, movf);
        if (trace_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                chk("payload", got, sb[0]);
                if (trace_ready) void'(sb.pop_front());
            end
        end else begin
            chk("masked", got, 0);
        end
    end

    task automatic cyc(bit v, logic [31:0] ins, logic [4:0] r, bit rw,
                       logic [31:0] d, bit rdy, bit c = 1'b0);
        bit   pop;
        bit   push;
        rec_t e;
        wb_valid    = v;
        wb_instr    = ins;
        wb_rd       = r;
        wb_regwrite = rw;
        wb_data     = d;
        trace_ready = rdy;
        clr         = c;
        @(posedge clk);
        if (c) begin
            mlevel = 0;
            mret   = '0;
            mdrop  = 0;
            movf   = 1'b0;
            sb.delete();
        end else begin
            pop  = (mlevel > 0) && rdy;
            push = v && ((mlevel < DEPTH) || pop);
            if (v) begin
                if (push) begin
                    e = '{ins, r, rw && (r != 5'd0), d, mret[SEQ_W-1:0]};
                    sb.push_back(e);
                end else begin
                    if (mdrop < 65535) mdrop++;
                    movf = 1'b1;
                end
                mret = mret + 32'd1;
            end
            mlevel = mlevel + int'(push) - int'(pop);
        end
        #1;
    endtask

    task automatic rnd(bit v, bit rdy);
        cyc(v, $urandom, 5'($urandom), 1'($urandom), $urandom, rdy);
    endtask

    task automatic idle(bit rdy);
        cyc(0, '0, '0, 0, '0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        clr = 0; wb_valid = 0; wb_instr = '0; wb_rd = '0;
        wb_regwrite = 0; wb_data = '0; trace_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", trace_valid, 0);
        chk("rst_retired", retired_count, 0);
        reset = 1'b0;

        cyc(1, 32'h00500093, 5'd1, 1, 32'd5, 1);
        chk("first_seq", trace_seq, 0);
        chk("first_we", trace_we, 1);
        cyc(1, 32'h00A00113, 5'd2, 1, 32'd10, 1);
        cyc(1, 32'h002081B3, 5'd3, 1, 32'd15, 1);
        idle(1);
        chk("three_ret", retired_count, 3);
        chk("three_lvl", level, 0);

        cyc(1, 32'h00000013, 5'd0, 1, 32'd7, 0);
        chk("rd0_we", trace_we, 0);
        chk("rd0_rd", trace_rd, 0);
        chk("rd0_seq", trace_seq, 3);
        idle(1);

        cyc(0, '0, '0, 0, '0, 0, 1);
        for (int i = 0; i < 10; i++) rnd(1, 0);
        chk("full_lvl", level, 8);
        chk("full_drop", dropped_count, 2);
        chk("full_ovf", overflow, 1);
        chk("full_ret", retired_count, 10);
        rnd(1, 1);
        chk("fullpp_lvl", level, 8);
        chk("fullpp_drop", dropped_count, 2);
        for (int i = 0; i < 200 && mlevel > 0; i++) idle(1'($urandom));
        chk("drain_lvl", level, 0);

        cyc(0, '0, '0, 0, '0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            rnd(1, 1);
            chk("pp_le1", level <= 1, 1);
        end
        idle(1);
        chk("pp_ret", retired_count, 20);
        chk("pp_drop", dropped_count, 0);

        cyc(0, '0, '0, 0, '0, 0, 1);
        for (int i = 0; i < 5; i++) rnd(1, 0);
        chk("mid_lvl", level, 5);
        wb_valid = 0;
        #2;
        reset = 1'b1;
        mlevel = 0; mret = '0; mdrop = 0; movf = 0;
        sb.delete();
        #1;
        chk("async_valid", trace_valid, 0);
        chk("async_lvl", level, 0);
        chk("async_ret", retired_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rnd(1, 0);
        chk("post_rst_seq", trace_seq, 0);
        rnd(1, 0);
        rnd(1, 0);
        cyc(1, 32'hDEADBEEF, 5'd4, 1, 32'd1, 1, 1);
        chk("clr_ret", retired_count, 0);
        chk("clr_lvl", level, 0);
        rnd(1, 0);
        chk("post_clr_seq", trace_seq, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cyc(1'($urandom), $urandom, 5'($urandom), 1, $urandom, 1'($urandom), 1);
            end else begin
                rnd(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45));
            end
        end
        for (int i = 0; i < 100 && mlevel > 0; i++) idle(1);
        chk("end_lvl", level, 0);
        chk("end_sb", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Captures every instruction retiring from the MEM/WB pipeline register and queues a trace record for an off-core consumer through a valid/ready handshake. Bubbles are excluded and retirements that arrive while the queue is full are counted as dropped. Sits beside the writeback stage and reads the same MEM/WB fields the register file consumes; it never stalls the pipeline. Also maintains retired and dropped counters for the debug block.

## Interface
- DEPTH, 8: queue entries; power of two, 2..64.
- SEQ_W, 16: width of the per-record sequence number.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clr  in  1  synchronous clear of queue, counters and sticky flag.
- wb_valid  in  1  a real (non-bubble) instruction occupies MEM/WB this cycle.
- wb_instr  in  32  Curr_Instr of the retiring instruction.
- wb_rd  in  5  destination register.
- wb_regwrite  in  1  RegWrite of the retiring instruction.
- wb_data  in  32  final writeback value (after the MemtoReg/Jal/Jalr mux).
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts head record.
- trace_instr  out  32  head record instruction.
- trace_rd  out  5  head record rd.
- trace_we  out  1  head record register write; 0 when rd == 0.
- trace_data  out  32  head record writeback value.
- trace_seq  out  SEQ_W  retirement index of head record, low SEQ_W bits.
- level  out  $clog2(DEPTH)+1  entries currently held.
- retired_count  out  32  total retirements seen.
- dropped_count  out  16  retirements lost to a full queue; saturates at 0xFFFF.
- overflow  out  1  sticky; set on first drop.

## Operation
- Push condition: wb_valid=1 and (level < DEPTH, or level == DEPTH with trace_valid & trace_ready in the same cycle).
- Each push stores {wb_instr, wb_rd, wb_regwrite & (wb_rd != 0), wb_data, retired_count[SEQ_W-1:0]}.
- Pop condition: trace_valid & trace_ready. The read pointer advances and the next record is presented.
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. level is tracked separately and is incremented, decremented or held. Push and pop in the same cycle leave level unchanged.
- Drop: when wb_valid=1 and the push condition fails, nothing is stored, dropped_count increments (saturating) and overflow sets.
- retired_count increments on every wb_valid=1, whether the record is pushed or dropped, and wraps at 2^32. Sequence gaps at the consumer therefore identify drops.
- clr=1: pointers, level, both counters and overflow go to 0. A wb_valid in the same cycle is ignored (not counted, not stored). A pop in the same cycle is discarded.
- reset: identical effect to clr, but asynchronous.
- There is no backpressure to the core; wb_valid is never refused.

## Timing
- Reset values:
  - trace_valid=0, level=0, retired_count=0, dropped_count=0, overflow=0.
  - trace_instr/rd/we/data/seq=0 (storage is not cleared; the payload is masked to 0 while trace_valid=0).
- Push-to-visible latency is 1 cycle: a record pushed at edge N drives trace_valid=1 and its payload from edge N onward (registered storage, combinational read of the head).
- trace_valid is a function of level != 0 only. It never depends on trace_ready.
- While trace_valid=1 and trace_ready=0, the payload holds stable.
- Counters and overflow update at the same edge as the push or drop they record.
- level == DEPTH is full; level == 0 is empty. A pop attempt when empty is impossible because trace_valid=0.

## Test plan
- Reset, then 3 retirements with instr 0x00500093, 0x00A00113, 0x002081B3 (rd 1,2,3, data 5,10,15), trace_ready=1 -> three records in order with seq 0,1,2 and trace_we=1. Each appears 1 cycle after its wb_valid. retired_count=3, level returns to 0.
- Retirement with wb_rd=0, wb_regwrite=1 -> trace_we=0, trace_rd=0, seq assigned normally.
- trace_ready=0, 10 consecutive wb_valid with DEPTH=8:
  - level=8, dropped_count=2, overflow=1, retired_count=10.
  - Then draining yields seq 0..7 with the head payload stable throughout the stall.
- Queue full with trace_ready=1 and wb_valid=1 in the same cycle -> record accepted, level stays 8, dropped_count unchanged.
- Continuous push/pop through 20 records -> pointers wrap twice, seq 0..19 delivered with no gaps and level stays at most 1.
- Assert reset asynchronously mid-stream with level=5 -> trace_valid falls immediately, all counters 0; the first post-reset retirement gets seq 0. Repeat using clr together with wb_valid -> that retirement is neither counted nor stored.
